// File: rtl/reg_univ.sv
// Universal WIDTH-bit register: hold/load/shift/rotate/clear plus multi-cycle rotate-left-by-N.
// Optional registered parity output enabled by defining REG_UNIV_PARITY_EN.
module reg_univ #(
  parameter int              WIDTH   = 8,
  parameter int              AW      = 3,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
`ifdef REG_UNIV_PARITY_EN
  ,
  output logic             parity
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] CNT_MAX = AW'(WIDTH - 1);

  function automatic logic calc_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath decode
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          case (mode)
            3'b000: data_d = data_q;
            3'b001: data_d = din;
            3'b010: data_d = {data_q[WIDTH-2:0], sin_r};
            3'b011: data_d = {sin_l, data_q[WIDTH-1:1]};
            3'b100: data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            3'b101: data_d = {data_q[0], data_q[WIDTH-1:1]};
            3'b110: data_d = RST_VAL;
            3'b111: begin
              // Out-of-range counts saturate to a full rotation minus one
              state_d = S_RUN;
              busy_d  = 1'b1;
              if (int'(amt) > (WIDTH - 1)) begin
                cnt_d = CNT_MAX;
              end else begin
                cnt_d = amt;
              end
            end
            default: data_d = data_q;
          endcase
        end else begin
          data_d = data_q;
        end
      end
      S_RUN: begin
        if (cnt_q != {AW{1'b0}}) begin
          data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
          cnt_d  = cnt_q - AW'(1'b1);
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= RST_VAL;
      cnt_q   <= {AW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q      = data_q;
  assign sout_l = data_q[WIDTH-1];
  assign sout_r = data_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef REG_UNIV_PARITY_EN
  logic parity_q;

  // Parity taken from next-q so it lines up with q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= calc_parity(RST_VAL);
    end else begin
      parity_q <= calc_parity(data_d);
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_reg_univ.sv
// Scoreboard bench for reg_univ: driver queues hand-computed expectations, monitor checks after each edge.
module tb_reg_univ;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] din;
  logic       sin_l;
  logic       sin_r;
  logic [2:0] amt;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic       busy;
  logic       done;
`ifdef REG_UNIV_PARITY_EN
  logic       parity;
`endif

  reg_univ #(.WIDTH(8), .AW(3), .RST_VAL(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .mode   (mode),
    .din    (din),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .amt    (amt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
`ifdef REG_UNIV_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  typedef struct packed {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   vec_id  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: after every rising edge, compare against the oldest expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("q[%0d]", vec_id), {24'h0, q}, {24'h0, e.q});
      chk($sformatf("busy[%0d]", vec_id), {31'h0, busy}, {31'h0, e.busy});
      chk($sformatf("done[%0d]", vec_id), {31'h0, done}, {31'h0, e.done});
      chk($sformatf("sout_l[%0d]", vec_id), {31'h0, sout_l}, {31'h0, e.q[7]});
      chk($sformatf("sout_r[%0d]", vec_id), {31'h0, sout_r}, {31'h0, e.q[0]});
`ifdef REG_UNIV_PARITY_EN
      chk($sformatf("parity[%0d]", vec_id), {31'h0, parity}, {31'h0, ^e.q});
`endif
      vec_id++;
    end
  end

  // Rotate counts at or beyond the register width would be clamped by the DUT
  always @(posedge clk) begin
    if (rst_n && en && (mode == 3'b111) && !busy) begin
      assert (int'(amt) < 8) else $error("rotate count %0d exceeds register width", amt);
    end
  end

  task automatic drive(input logic r, input logic e, input logic [2:0] m, input logic [7:0] d,
                       input logic sl, input logic sr, input logic [2:0] a,
                       input logic [7:0] eq, input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    rst_n = r;
    en    = e;
    mode  = m;
    din   = d;
    sin_l = sl;
    sin_r = sr;
    amt   = a;
    x.q    = eq;
    x.busy = eb;
    x.done = ed;
    sb_q.push_back(x);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 3'b000; din = 8'h00;
    sin_l = 1'b0; sin_r = 1'b0; amt = 3'd0;

    // reset, load, shifts
    drive(1'b0, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 3'd0, 8'hA5, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 3'd0, 8'h4B, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b011, 8'h00, 1'b0, 1'b1, 3'd0, 8'h25, 1'b0, 1'b0);
    // en low holds, even with the clear mode selected
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 3'b110, 8'h00, 1'b1, 1'b1, 3'd0, 8'h25, 1'b0, 1'b0);
    end
    // rotates and clear
    drive(1'b1, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 3'd0, 8'h03, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 3'd0, 8'h81, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    // multi-rotate by 3 with a load attempted while busy
    drive(1'b1, 1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd3, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h02, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h04, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h08, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 3'd5, 8'h08, 1'b0, 1'b1);
    // command in the done cycle is accepted
    drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 3'd0, 8'h11, 1'b0, 1'b0);
    // amt = 0
    drive(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd0, 8'h11, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 3'b000, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h11, 1'b0, 1'b0);
    // amt = 7 abandoned by reset on the third RUN cycle
    drive(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd7, 8'h11, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h22, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h44, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
    end
    // back-to-back: new rotate issued in the done cycle, done stays low
    drive(1'b1, 1'b1, 3'b001, 8'h80, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd1, 8'h80, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h01, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 3'd2, 8'h01, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h02, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 3'd0, 8'h04, 1'b0, 1'b0);
    // parity-oriented vectors
    drive(1'b1, 1'b1, 3'b001, 8'h07, 1'b0, 1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b010, 8'h00, 1'b0, 1'b0, 3'd0, 8'h0E, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 3'b001, 8'h03, 1'b0, 1'b0, 3'd0, 8'h03, 1'b0, 1'b0);

    @(posedge clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
